fm_nco_synth: RTL and testbench

Parametrised phase-continuous NCO for the FM distance-tone path. It accepts frequency-step words through a valid/ready handshake and slews the active step toward each new target at a programmable rate, so retunes are click-free. A pipelined quarter-wave sine lookup drives an offset-binary sample for the R-2R or PWM DAC. A per-cycle advance strobe lets the same block feed either DAC style.

---
 rtl/fm_nco_pkg.sv | 45 ++++
 rtl/fm_nco_synth_rom.sv | 40 ++++
 rtl/fm_nco_synth.sv | 139 +++++++++++++
 tb/tb_fm_nco_synth.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_nco_pkg.sv
// rtl/fm_nco_pkg.sv - shared types, constants and ROM helpers for the FM distance-tone NCO
//
// Purpose: output-mode and retune-state encodings, the offset-binary midpoint,
// and the quarter-wave table entry formula used to build the sine ROM.
// Ports: none (package).
package fm_nco_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_HOLD    = 2'b01,
    MODE_MUTE    = 2'b10,
    MODE_RUN_ALT = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } retune_state_e;

  // Name under which the generated quarter-wave table is exported; the ROM
  // evaluates the same entry formula below when it is elaborated.
  localparam string ROM_INIT_FILE = "quarter_sine.mem";

  // Offset-binary midpoint for a sample of the given width.
  function automatic int sine_mid(input int width);
    return 1 << (width - 1);
  endfunction

  // round(amp * sin((i + 0.5) * pi / 2^(addr_w+1))), sine by Taylor series.
  // The argument never exceeds pi/2, so eight terms are far more than enough.
  function automatic int quarter_sine_entry(input int i, input int addr_w, input int amp);
    real x;
    real term;
    real s;
    x    = (real'(i) + 0.5) * 3.14159265358979323846 / real'(1 << (addr_w + 1));
    term = x;
    s    = x;
    for (int k = 1; k <= 8; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    return $rtoi(real'(amp) * s + 0.5);
  endfunction

endpackage

// File: rtl/fm_nco_synth_rom.sv
// rtl/fm_nco_synth_rom.sv - synchronous-read quarter-wave sine ROM
//
// Purpose: magnitude table for the first quarter of a sine, registered read.
// Ports:
//   clk, reset  clock and synchronous active-high reset (clears the read register)
//   enable      read register updates only when high
//   addr        table index
//   data        registered magnitude, 0 .. 2^DATA_WIDTH-1
module quarter_sine_rom
  import fm_nco_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AMP   = (1 << DATA_WIDTH) - 1;

  logic [DATA_WIDTH-1:0] rom_table [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [DATA_WIDTH-1:0] ENTRY = DATA_WIDTH'(quarter_sine_entry(i, ADDR_WIDTH, AMP));
    assign rom_table[i] = ENTRY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (enable) begin
      data <= rom_table[addr];
    end
  end

endmodule

// File: rtl/fm_nco_synth.sv
// rtl/fm_nco_synth.sv - phase-continuous slewed-retune NCO with pipelined quarter-wave sine
//
// Purpose: accepts target frequency steps by valid/ready, slews the active step
// toward the target, accumulates phase and produces an offset-binary sine sample.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   enable        global clock enable, low freezes everything
//   advance       phase-advance strobe
//   mode          00 run, 01 hold phase, 10 mute output, 11 run
//   step_valid/step_ready/step_data  target step handshake
//   slew_rate     max step change per enable cycle, 0 = immediate
//   retune_busy   ramp in progress
//   phase_out     accumulator
//   sine_out      offset-binary sample, 3 enable cycles behind phase_out
//   out_valid     sine_out carries a real phase sample
module fm_nco_synth
  import fm_nco_pkg::*;
#(
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int SINE_WIDTH     = 7,
  parameter int SLEW_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   advance,
  input  logic [1:0]             mode,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [PHASE_WIDTH-1:0] step_data,
  input  logic [SLEW_WIDTH-1:0]  slew_rate,
  output logic                   retune_busy,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic [SINE_WIDTH-1:0]  sine_out,
  output logic                   out_valid
);

  localparam int                    DW     = SINE_WIDTH - 1;
  localparam logic [SINE_WIDTH-1:0] MID    = SINE_WIDTH'(sine_mid(SINE_WIDTH));
  localparam logic [SINE_WIDTH-1:0] MID_M1 = MID - SINE_WIDTH'(1);

  retune_state_e          state;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] cur_step;
  logic [PHASE_WIDTH-1:0] target;
  logic [PHASE_WIDTH-1:0] diff;
  logic [PHASE_WIDTH-1:0] slew_ext;
  logic                   slew_done;

  logic                      s1_neg;
  logic [LUT_ADDR_WIDTH-1:0] s1_idx;
  logic                      s2_neg;
  logic [DW-1:0]             rom_data;
  logic                      v1;
  logic                      v2;

  always_comb begin
    diff      = (target >= cur_step) ? (target - cur_step) : (cur_step - target);
    slew_ext  = PHASE_WIDTH'(slew_rate);
    slew_done = (slew_rate == '0) || (diff <= slew_ext);
  end

  // Ready gates on reset as well so nothing can be accepted during reset.
  assign step_ready  = enable && !reset && (state == ST_IDLE);
  assign retune_busy = (state == ST_RAMP);
  assign phase_out   = phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      phase    <= '0;
      cur_step <= '0;
      target   <= '0;
    end else if (enable) begin
      // Uses cur_step before this cycle's ramp update.
      if (advance && (mode != MODE_HOLD)) begin
        phase <= phase + cur_step;
      end
      if (state == ST_IDLE) begin
        if (step_valid) begin
          target <= step_data;
          state  <= ST_RAMP;
        end
      end else begin
        if (slew_done) begin
          cur_step <= target;
          state    <= ST_IDLE;
        end else if (target > cur_step) begin
          cur_step <= cur_step + slew_ext;
        end else begin
          cur_step <= cur_step - slew_ext;
        end
      end
    end
  end

  // Stage 1: quadrant sign and mirrored table index (odd quadrants run backwards).
  // Stage 2: registered ROM read, sign carried alongside.
  // Stage 3: fold into offset binary, mute overrides.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_neg    <= 1'b0;
      s1_idx    <= '0;
      s2_neg    <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      sine_out  <= MID;
    end else if (enable) begin
      s1_neg    <= phase[PHASE_WIDTH-1];
      s1_idx    <= phase[PHASE_WIDTH-2] ? ~phase[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH]
                                        :  phase[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
      s2_neg    <= s1_neg;
      v1        <= 1'b1;
      v2        <= v1;
      out_valid <= v2;
      if (mode == MODE_MUTE) begin
        sine_out <= MID;
      end else if (s2_neg) begin
        sine_out <= MID_M1 - {1'b0, rom_data};
      end else begin
        sine_out <= MID + {1'b0, rom_data};
      end
    end
  end

  quarter_sine_rom #(
    .ADDR_WIDTH(LUT_ADDR_WIDTH),
    .DATA_WIDTH(DW)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .addr  (s1_idx),
    .data  (rom_data)
  );

endmodule

// File: tb/tb_fm_nco_synth.sv
// tb/tb_fm_nco_synth.sv - self-checking bench for fm_nco_synth
module tb_fm_nco_synth;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        advance;
  logic [1:0]  mode;
  logic        step_valid;
  logic        step_ready;
  logic [31:0] step_data;
  logic [15:0] slew_rate;
  logic        retune_busy;
  logic [31:0] phase_out;
  logic [6:0]  sine_out;
  logic        out_valid;

  always #5 clk = ~clk;

  fm_nco_synth #(
    .PHASE_WIDTH(32), .LUT_ADDR_WIDTH(10), .SINE_WIDTH(7), .SLEW_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .advance(advance), .mode(mode),
    .step_valid(step_valid), .step_ready(step_ready), .step_data(step_data),
    .slew_rate(slew_rate), .retune_busy(retune_busy), .phase_out(phase_out),
    .sine_out(sine_out), .out_valid(out_valid)
  );

  int total = 0;
  int bad   = 0;
  int hs_count = 0;

  // reference model state
  logic [31:0] m_phase, m_cur, m_tgt;
  bit          m_ramp;
  int          m_vcnt, m_sine;
  int          sine_q[$];

  typedef struct {
    logic        adv;
    logic [31:0] phase;
    int          sine;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_sine(input logic [31:0] p);
    logic [1:0] q;
    logic [9:0] idx;
    real        th;
    int         m;
    q   = p[31:30];
    idx = p[29:20];
    if (q[0]) idx = ~idx;
    th = (real'(idx) + 0.5) * 3.141592653589793 / 2048.0;
    m  = $rtoi(63.0 * $sin(th) + 0.5);
    return q[1] ? (63 - m) : (64 + m);
  endfunction

  task automatic model_reset();
    m_phase = '0; m_cur = '0; m_tgt = '0; m_ramp = 1'b0;
    m_vcnt = 0; m_sine = 64;
    sine_q.delete();
  endtask

  // One clock: check handshake outputs before the edge, advance the model,
  // then check registered outputs 1 time unit after the edge.
  task automatic tick();
    logic [31:0] diff;
    int raw;
    #2;
    check("step_ready", step_ready, (enable && !reset && !m_ramp));
    check("retune_busy", retune_busy, m_ramp);
    if (step_valid && step_ready) hs_count++;
    if (reset) begin
      model_reset();
    end else if (enable) begin
      sine_q.push_back(ref_sine(m_phase));
      if (sine_q.size() == 3) begin
        raw    = sine_q.pop_front();
        m_sine = (mode == 2'b10) ? 64 : raw;
      end else begin
        m_sine = 64;
      end
      if (m_vcnt < 3) m_vcnt++;
      if (advance && mode != 2'b01) m_phase = m_phase + m_cur;
      if (!m_ramp) begin
        if (step_valid) begin
          m_tgt  = step_data;
          m_ramp = 1'b1;
        end
      end else begin
        diff = (m_tgt >= m_cur) ? (m_tgt - m_cur) : (m_cur - m_tgt);
        if (slew_rate == 0 || diff <= 32'(slew_rate)) begin
          m_cur  = m_tgt;
          m_ramp = 1'b0;
        end else if (m_tgt > m_cur) begin
          m_cur = m_cur + 32'(slew_rate);
        end else begin
          m_cur = m_cur - 32'(slew_rate);
        end
      end
    end
    @(posedge clk);
    #1;
    check("phase_out", phase_out, m_phase);
    check("out_valid", out_valid, (m_vcnt >= 3));
    check("sine_out", sine_out, m_sine);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (retune_busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", retune_busy, 0);
  endtask

  // one-shot retune: offer a step for one cycle
  task automatic retune(input logic [31:0] data, input logic [15:0] slew);
    step_data  = data;
    slew_rate  = slew;
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
  endtask

  initial begin
    vec_t        tbl[8];
    logic [31:0] prev, saved_p;
    logic [6:0]  saved_s;
    int          exp_d[4];
    int          exp_b[4];
    int          idx, busy_cnt, hs0, n;
    logic [31:0] b2b[3];

    tbl[0] = '{1'b1, 32'h4000_0000, 127};
    tbl[1] = '{1'b1, 32'h8000_0000, 63};
    tbl[2] = '{1'b1, 32'hC000_0000, 0};
    tbl[3] = '{1'b1, 32'h0000_0000, 64};
    tbl[4] = '{1'b0, 32'h0000_0000, 64};
    tbl[5] = '{1'b1, 32'h4000_0000, 127};
    tbl[6] = '{1'b1, 32'h8000_0000, 63};
    tbl[7] = '{1'b1, 32'hC000_0000, 0};

    reset = 1'b1; enable = 1'b1; advance = 1'b1; mode = 2'b00;
    step_valid = 1'b0; step_data = '0; slew_rate = '0;

    // reset for 3 cycles
    @(posedge clk); #1;
    model_reset();
    tick();
    tick();
    check("rst_phase", phase_out, 0);
    check("rst_sine", sine_out, 64);
    check("rst_valid", out_valid, 0);
    check("rst_ready", step_ready, 0);

    reset = 1'b0;
    #1;
    check("rel_ready", step_ready, 1);
    tick();
    tick();
    check("valid_lag2", out_valid, 0);
    tick();
    check("valid_lag3", out_valid, 1);

    // quadrant sweep, immediate retune
    retune(32'h4000_0000, 16'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      advance = tbl[i].adv;
      tick();
      check("tbl_phase", phase_out, tbl[i].phase);
      if (i >= 3) check("tbl_sine", sine_out, tbl[i-3].sine);
    end
    advance = 1'b1;

    // slewed ramp 1000 -> 1300 by 100
    retune(32'd1000, 16'd0);
    tick();
    step_data = 32'd1300; slew_rate = 16'd100; step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    check("ramp_busy0", retune_busy, 1);
    exp_d = '{1000, 1100, 1200, 1300};
    exp_b = '{1, 1, 0, 0};
    for (int j = 0; j < 4; j++) begin
      prev = phase_out;
      tick();
      check("ramp_delta", phase_out - prev, exp_d[j]);
      check("ramp_busy", retune_busy, exp_b[j]);
    end

    // 1300 -> 1250 in one update, no overshoot
    retune(32'd1250, 16'd100);
    exp_d = '{1300, 1250, 1250, 1250};
    for (int j = 0; j < 3; j++) begin
      prev = phase_out;
      tick();
      check("down_delta", phase_out - prev, exp_d[j]);
      check("down_busy", retune_busy, 0);
    end

    // HOLD and advance low freeze the phase; mode 11 runs
    saved_p = phase_out;
    mode = 2'b01;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("hold_phase", phase_out, saved_p);
    end
    mode = 2'b00; advance = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      check("noadv_phase", phase_out, saved_p);
    end
    advance = 1'b1;
    mode = 2'b11;
    tick();
    check("mode3_phase", phase_out, saved_p + 32'd1250);
    mode = 2'b00;

    // MUTE forces midpoint one cycle later, RUN resumes without a phase jump
    mode = 2'b10;
    tick();
    check("mute_sine", sine_out, 64);
    tick();
    tick();
    check("mute_sine2", sine_out, 64);
    mode = 2'b00;
    for (int j = 0; j < 4; j++) begin
      prev = phase_out;
      tick();
      check("unmute_delta", phase_out - prev, 1250);
    end

    // enable low mid-ramp
    retune(32'd50000, 16'd1000);
    tick();
    tick();
    enable = 1'b0;
    saved_p = phase_out;
    saved_s = sine_out;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("frz_phase", phase_out, saved_p);
      check("frz_sine", sine_out, saved_s);
      check("frz_busy", retune_busy, 1);
    end
    enable = 1'b1;
    prev = phase_out;
    tick();
    check("thaw_delta", phase_out - prev, 3250);

    // reset mid-ramp
    reset = 1'b1;
    tick();
    check("mrst_phase", phase_out, 0);
    check("mrst_busy", retune_busy, 0);
    check("mrst_valid", out_valid, 0);
    reset = 1'b0;
    #1;
    check("mrst_ready", step_ready, 1);
    for (int j = 0; j < 3; j++) tick();
    check("mrst_cur0", phase_out, 0);

    // back-to-back targets with valid held
    b2b = '{32'd10, 32'd4, 32'd20};
    slew_rate = 16'd3;
    idx = 0;
    busy_cnt = 0;
    hs0 = hs_count;
    step_data = b2b[0];
    step_valid = 1'b1;
    n = 0;
    while ((idx < 3 || retune_busy) && n < 60) begin
      tick();
      n++;
      if (retune_busy) busy_cnt++;
      if (hs_count - hs0 > idx) begin
        idx++;
        if (idx < 3) step_data = b2b[idx];
        else step_valid = 1'b0;
      end
    end
    check("b2b_timeout", (n < 60), 1);
    check("b2b_accepts", hs_count - hs0, 3);
    check("b2b_busy", busy_cnt, 12);
    prev = phase_out;
    tick();
    check("b2b_final", phase_out - prev, 20);

    wait_idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
